arm_imm_encoder: RTL and testbench
==================================

Name: arm_imm_encoder

Overview:
Iterative encoder that converts a 32-bit constant into the ARM data-processing immediate shifter-operand field. The field is {rotate[3:0], imm8[7:0]}, with value = ROR(zero-extended imm8, 2*rotate). It is the inverse of the operand-2 immediate decode in the execute stage. The block is used by the instruction-builder and self-test logic to synthesize MOV/MVN encodings. It searches one rotation per clock behind a start/done handshake.

Parameters:
ALLOW_INVERT, 1, when 1 a constant whose bitwise complement is encodable is also accepted (MVN form), flagged by inverted.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
value  input  32  constant to encode; latched on accepted start
busy  output  1  high while searching
done  output  1  single-cycle pulse when result is ready
valid  output  1  result found; qualified by done, held until next start
inverted  output  1  result encodes ~value (MVN form); 0 when ALLOW_INVERT=0
shiftOperand  output  12  {rotate, imm8}; 12'h000 when valid=0

Behaviour:
- Reset (rst low, async): state=IDLE, busy=0, done=0, valid=0, inverted=0, shiftOperand=0, rotation counter=0. A reset mid-search aborts the search and produces no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at a rising edge latches value into an internal register, clears the counter r to 0, and enters SEARCH.
  - busy goes high on that same edge.
- SEARCH, one edge per candidate r:
  - Compute t = ROL(latched, 2r) and u = ROL(~latched, 2r); rotate amount is mod 32.
  - Direct match: t[31:8]==0.
  - Inverted match: u[31:8]==0 and ALLOW_INVERT=1.
  - On a direct match, register shiftOperand={r, t[7:0]}, valid=1, inverted=0, and go to DONE.
  - Otherwise, on an inverted match, register shiftOperand={r, u[7:0]}, valid=1, inverted=1, and go to DONE.
  - Otherwise, if r==15, register valid=0, inverted=0, shiftOperand=0, and go to DONE.
  - Otherwise r increments.
- Priority: the smallest r wins. At equal r, direct beats inverted.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - Results hold until the next accepted start. On that start, valid, inverted and shiftOperand are not cleared until the new result registers.
- Latency: for a match at rotation k, done is high in the cycle after edge k+2, counting the start-accept edge as edge 1. Worst case (k=15 or no match) is edge 17.
- start is ignored while in SEARCH or DONE; value changes are ignored after latching.
- start held high continuously begins a new search on the edge where IDLE is re-entered plus one, i.e. back-to-back operations with one IDLE cycle.
- Correctness invariant: whenever valid=1, ROR({24'b0, imm8}, 2*rotate) equals value if inverted=0, or ~value if inverted=1.
- value=0 encodes as r=0, imm8=0, direct.

Test Plan:
- value=32'h000000FF, start 1 cycle -> done at edge 2; valid=1, inverted=0, shiftOperand=12'h0FF.
- value=32'hFF000000 -> done at edge 6; shiftOperand=12'h4FF, valid=1, inverted=0.
- value=32'h00000104 -> done at edge 17; shiftOperand=12'hF41, valid=1.
- value=32'h00000101 -> done at edge 17; valid=0, inverted=0, shiftOperand=12'h000.
- value=32'hFFFFFF00 with ALLOW_INVERT=1 -> edge 2, inverted=1, shiftOperand=12'h0FF. Same value with ALLOW_INVERT=0 -> edge 17, valid=0.
- Start 32'h00000104 and pulse start again at edge 5 with value=0 -> second start is ignored and the first result is 12'hF41. Separately, rst low at edge 8 of a search -> all outputs 0 immediately and no done pulse. Randomized sweep -> every valid result satisfies the decode invariant.

Source files
------------

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder
// Iterative encoder from a 32-bit constant to the ARM data-processing
// immediate field {rotate[3:0], imm8[7:0]}, where the decoded value is
// ROR(zero-extended imm8, 2*rotate). One rotation is tried per clock.
//
// Handshake: start is sampled only in IDLE. The accepting edge latches value
// and raises busy. When the search ends, done pulses high for exactly one
// cycle while busy is low. valid, inverted and shiftOperand are qualified by
// done and hold until the next search registers a new result.
module arm_imm_encoder #(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        inverted,
    output logic [11:0] shiftOperand,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] value_q;
    logic [3:0]  r_q;

    logic [4:0]  rot_amt;
    logic [31:0] t_rot;
    logic [31:0] u_rot;
    logic        direct_hit;
    logic        invert_hit;

    // Rotate left by amt using a doubled word so that amt=0 needs no special case.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] d;
        d = {x, x} << amt;
        return d[63:32];
    endfunction

    // Candidate rotations for the current r; a match leaves only the low byte set.
    always_comb begin
        rot_amt    = {r_q, 1'b0};
        t_rot      = rol32(value_q, rot_amt);
        u_rot      = rol32(~value_q, rot_amt);
        direct_hit = (t_rot[31:8] == 24'd0);
        invert_hit = ALLOW_INVERT && (u_rot[31:8] == 24'd0);
    end

    // Control FSM with registered outputs; reset aborts any search silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            value_q      <= 32'd0;
            r_q          <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            valid        <= 1'b0;
            inverted     <= 1'b0;
            shiftOperand <= 12'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        value_q <= value;
                        r_q     <= 4'd0;
                        busy    <= 1'b1;
                        state_q <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (direct_hit) begin
                        shiftOperand <= {r_q, t_rot[7:0]};
                        valid        <= 1'b1;
                        inverted     <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state_q      <= FINISH;
                    end else if (invert_hit) begin
                        shiftOperand <= {r_q, u_rot[7:0]};
                        valid        <= 1'b1;
                        inverted     <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state_q      <= FINISH;
                    end else if (r_q == 4'd15) begin
                        shiftOperand <= 12'd0;
                        valid        <= 1'b0;
                        inverted     <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state_q      <= FINISH;
                    end else begin
                        r_q <= r_q + 4'd1;
                    end
                end
                FINISH: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Testbench for arm_imm_encoder: two instances (ALLOW_INVERT=1 and =0) share
// the stimulus; each has its own expected queue and done-triggered monitor.
module tb_arm_imm_encoder;

    localparam int W = 62; // {done_edge[15:0], valid, inverted, shiftOperand[11:0], value[31:0]}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] value;

    logic        busy_a, done_a, valid_a, inv_a;
    logic [11:0] so_a;
    logic [1:0]  st_a;
    logic        busy_b, done_b, valid_b, inv_b;
    logic [11:0] so_b;
    logic [1:0]  st_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    arm_imm_encoder #(.ALLOW_INVERT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_a), .done(done_a), .valid(valid_a), .inverted(inv_a),
        .shiftOperand(so_a), .dbg_state(st_a)
    );

    arm_imm_encoder #(.ALLOW_INVERT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy_b), .done(done_b), .valid(valid_b), .inverted(inv_b),
        .shiftOperand(so_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int amt);
        logic [63:0] d;
        d = {x, x} << amt;
        return d[63:32];
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int amt);
        logic [63:0] d;
        d = {x, x} >> amt;
        return d[31:0];
    endfunction

    // Reference: smallest rotation whose rotated word fits in a byte; direct first.
    task automatic model(input logic [31:0] v, input bit allow, output bit vld,
                         output bit inv, output logic [11:0] so, output int k);
        logic [31:0] t;
        logic [31:0] u;
        logic [3:0]  rr;
        vld = 1'b0; inv = 1'b0; so = 12'd0; k = 15;
        for (int r = 0; r < 16; r++) begin
            t  = rol(v, 2 * r);
            u  = rol(~v, 2 * r);
            rr = 4'(r);
            if (t < 32'd256) begin
                vld = 1'b1; so = {rr, t[7:0]}; k = r; break;
            end
            if (allow && (u < 32'd256)) begin
                vld = 1'b1; inv = 1'b1; so = {rr, u[7:0]}; k = r; break;
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] v, input int accept, output int k);
        bit vld, inv;
        logic [11:0] so;
        int kb;
        model(v, 1'b1, vld, inv, so, k);
        exp_a.push_back({16'(accept + k + 1), vld, inv, so, v});
        model(v, 1'b0, vld, inv, so, kb);
        exp_b.push_back({16'(accept + kb + 1), vld, inv, so, v});
        n_vec++;
    endtask

    // ---------------- monitor ----------------
    task automatic check_result(input string tag, input logic [W-1:0] e, input logic bsy,
                                input logic vld, input logic inv, input logic [11:0] so);
        logic [31:0] dec;
        cmp({tag, "_latency"}, cyc, {16'd0, e[61:46]});
        cmp({tag, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
        cmp({tag, "_valid"}, {31'd0, vld}, {31'd0, e[45]});
        cmp({tag, "_inverted"}, {31'd0, inv}, {31'd0, e[44]});
        cmp({tag, "_shiftOperand"}, {20'd0, so}, {20'd0, e[43:32]});
        if (vld) begin
            dec = ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
            cmp({tag, "_decode"}, dec, inv ? ~e[31:0] : e[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst && done_a) begin
            if (exp_a.size() == 0) cmp("a_unexpected_done", 32'd1, 32'd0);
            else check_result("a", exp_a.pop_front(), busy_a, valid_a, inv_a, so_a);
        end
    end

    always @(negedge clk) begin
        if (rst && done_b) begin
            if (exp_b.size() == 0) cmp("b_unexpected_done", 32'd1, 32'd0);
            else check_result("b", exp_b.pop_front(), busy_b, valid_b, inv_b, so_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] v, output int accept);
        int k;
        @(negedge clk);
        start  = 1'b1;
        value  = v;
        accept = cyc + 1;
        push_exp(v, accept, k);
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
        cmp("busy_after_accept", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (exp_a.size() == 0 && exp_b.size() == 0 && !busy_a && !busy_b && !done_a && !done_b)
                return;
        end
        cmp("wait_idle_timeout", 32'd1, 32'd0);
        exp_a.delete();
        exp_b.delete();
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] x;
        case ($urandom_range(0, 3))
            0: x = $urandom;
            1: x = ror({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
            2: x = ~ror({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
            default: x = ror({24'd0, 8'($urandom)}, $urandom_range(0, 31));
        endcase
        return x;
    endfunction

    // ---------------- main sequence ----------------
    logic [31:0] directed[7];
    int acc;
    int k_held;

    initial begin
        directed[0] = 32'h000000FF;
        directed[1] = 32'hFF000000;
        directed[2] = 32'h00000104;
        directed[3] = 32'h00000101;
        directed[4] = 32'hFFFFFF00;
        directed[5] = 32'h00000000;
        directed[6] = 32'hFFFFFFFF;

        rst = 1'b0; start = 1'b0; value = 32'd0;
        repeat (3) @(negedge clk);
        cmp("reset_outputs_a", {14'd0, busy_a, done_a, valid_a, inv_a, so_a, st_a}, 32'd0);
        cmp("reset_outputs_b", {14'd0, busy_b, done_b, valid_b, inv_b, so_b, st_b}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(directed[i], acc);
            wait_idle();
        end

        // Second start during SEARCH must be ignored.
        issue(32'h00000104, acc);
        repeat (4) @(negedge clk);
        start = 1'b1;
        value = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        cmp("busy_after_ignored_start", {31'd0, busy_a}, 32'd0);

        // Reset at edge 8 of a search: outputs clear at once, no done pulse.
        issue(32'h00000104, acc);
        repeat (7) @(posedge clk);
        #2;
        cmp("result_held_during_search", {20'd0, so_a}, 32'h00000F41);
        rst = 1'b0;
        #1;
        cmp("midsearch_reset_a", {14'd0, busy_a, done_a, valid_a, inv_a, so_a, st_a}, 32'd0);
        cmp("midsearch_reset_b", {14'd0, busy_b, done_b, valid_b, inv_b, so_b, st_b}, 32'd0);
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        cmp("no_done_after_reset", {31'd0, busy_a}, 32'd0);

        // Start held high: back-to-back operations with one IDLE cycle between.
        @(negedge clk);
        start = 1'b1;
        value = 32'hFF000000;
        acc   = cyc + 1;
        push_exp(value, acc, k_held);
        push_exp(value, acc + k_held + 3, k_held);
        while (cyc < acc + k_held + 3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        // Randomized sweep.
        for (int i = 0; i < 40; i++) begin
            issue(rand_value(), acc);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
